// File: rtl/gray_pkg.sv
// Shared widths, output geometry and FSM encoding for the Bayer-to-gray downscaler.
package gray_pkg;

    localparam int unsigned DW      = 12;
    localparam int unsigned SUM_W   = 14;
    localparam int unsigned OUT_X_W = 10;
    localparam int unsigned OUT_Y_W = 10;
    localparam int unsigned OUT_W   = 640;
    localparam int unsigned OUT_H   = 480;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } gray_state_e;

endpackage

// File: rtl/gray_line_buffer.sv
// One-row line buffer: single-port RAM with registered read, read-before-write.
// Ports:
//   iCLK   - pixel clock
//   iEN    - access strobe; reads the old word at iADDR and writes iWDATA
//   iADDR  - column address
//   iWDATA - word written this access
//   oRDATA - word stored at iADDR before this access (one cycle later)
module gray_line_buffer #(
    parameter int unsigned DEPTH = 1280,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = 11
) (
    input  logic             iCLK,
    input  logic             iEN,
    input  logic [AW-1:0]    iADDR,
    input  logic [WIDTH-1:0] iWDATA,
    output logic [WIDTH-1:0] oRDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so no reset on the array or read port.
    always_ff @(posedge iCLK) begin
        if (iEN) begin
            oRDATA      <= mem[iADDR];
            mem[iADDR]  <= iWDATA;
        end
    end

endmodule

// File: rtl/bayer_gray_downscaler.sv
// Averages each 2x2 Bayer quad of the raw stream into one gray pixel,
// halving both dimensions.
// Ports:
//   iCLK, iRST        - pixel clock, asynchronous active-low reset
//   iDATA/iDVAL/iX/iY - raw Bayer pixel, valid strobe and its coordinates
//   oGray/oDVAL/oX/oY - averaged pixel, one-cycle strobe, output coordinates
//   oFrameDone        - pulses with the last output pixel of a frame
module bayer_gray_downscaler
    import gray_pkg::gray_state_e, gray_pkg::WAIT_SOF, gray_pkg::ACTIVE,
           gray_pkg::OUT_X_W, gray_pkg::OUT_Y_W;
#(
    parameter int unsigned IN_W = 1280,
    parameter int unsigned IN_H = 960,
    parameter int unsigned DW   = 12
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DW-1:0]      iDATA,
    input  logic               iDVAL,
    input  logic [15:0]        iX,
    input  logic [15:0]        iY,
    output logic [DW-1:0]      oGray,
    output logic               oDVAL,
    output logic [OUT_X_W-1:0] oX,
    output logic [OUT_Y_W-1:0] oY,
    output logic               oFrameDone
);

    localparam int unsigned ACC_W  = DW + 2;
    localparam int unsigned AW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [15:0] X_LIM  = 16'(IN_W);
    localparam logic [15:0] Y_LIM  = 16'(IN_H);
    localparam logic [15:0] X_LAST = 16'(IN_W - 1);
    localparam logic [15:0] Y_LAST = 16'(IN_H - 1);

    gray_state_e state_q;
    gray_state_e state_d;

    logic in_valid_c;
    logic sof_c;
    logic accept_c;
    logic trig_c;

    logic [DW-1:0]      buf_rd;
    logic [DW-1:0]      held_q;

    logic               s1_vld_q;
    logic               s1_last_q;
    logic [DW-1:0]      s1_al_q;
    logic [DW-1:0]      s1_l_q;
    logic [DW-1:0]      s1_c_q;
    logic [OUT_X_W-1:0] s1_x_q;
    logic [OUT_Y_W-1:0] s1_y_q;
    logic [ACC_W-1:0]   sum_c;

    assign in_valid_c = iDVAL && (iX < X_LIM) && (iY < Y_LIM);
    assign sof_c      = in_valid_c && (iX == 16'd0) && (iY == 16'd0);

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave WAIT_SOF on the first pixel of a frame; only reset returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof_c) state_d = ACTIVE;
            ACTIVE:   state_d = ACTIVE;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // Decode: the start-of-frame pixel itself is processed while still in WAIT_SOF.
    always_comb begin
        accept_c = 1'b0;
        trig_c   = 1'b0;
        case (state_q)
            WAIT_SOF: accept_c = sof_c;
            ACTIVE:   accept_c = in_valid_c;
            default:  accept_c = 1'b0;
        endcase
        trig_c = accept_c && iX[0] && iY[0];
    end

    // Every accepted pixel reads the previous row's word at iX and overwrites it.
    gray_line_buffer #(
        .DEPTH (IN_W),
        .WIDTH (DW),
        .AW    (AW)
    ) u_line_buffer (
        .iCLK   (iCLK),
        .iEN    (accept_c),
        .iADDR  (iX[AW-1:0]),
        .iWDATA (iDATA),
        .oRDATA (buf_rd)
    );

    // Current-row left neighbour; only valid pixels update it so gaps are harmless.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            held_q <= '0;
        end else if (accept_c) begin
            held_q <= iDATA;
        end
    end

    // Stage 1: on a trigger the RAM read port still holds buf[iX-1] from the
    // preceding even-column access; buf[iX] arrives on the read port next cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_al_q   <= '0;
            s1_l_q    <= '0;
            s1_c_q    <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
        end else begin
            s1_vld_q <= trig_c;
            if (trig_c) begin
                s1_last_q <= (iX == X_LAST) && (iY == Y_LAST);
                s1_al_q   <= buf_rd;
                s1_l_q    <= held_q;
                s1_c_q    <= iDATA;
                s1_x_q    <= OUT_X_W'(iX >> 1);
                s1_y_q    <= OUT_Y_W'(iY >> 1);
            end
        end
    end

    // Four DW-bit terms fit in DW+2 bits; dropping the two LSBs floors the mean.
    always_comb begin
        sum_c = ACC_W'(s1_al_q) + ACC_W'(buf_rd) + ACC_W'(s1_l_q) + ACC_W'(s1_c_q);
    end

    // Stage 2: registered outputs; data and coordinates hold between strobes.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oGray      <= '0;
            oDVAL      <= 1'b0;
            oX         <= '0;
            oY         <= '0;
            oFrameDone <= 1'b0;
        end else begin
            oDVAL      <= s1_vld_q;
            oFrameDone <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                oGray <= sum_c[ACC_W-1:2];
                oX    <= s1_x_q;
                oY    <= s1_y_q;
            end
        end
    end

endmodule

// File: tb/tb_bayer_gray_downscaler.sv
// Randomized bench for bayer_gray_downscaler on a reduced frame size, checked
// against an image-level model that averages quads straight from a frame array.
module tb_bayer_gray_downscaler;

    localparam int unsigned IN_W = 16;
    localparam int unsigned IN_H = 12;
    localparam int unsigned DW   = 12;
    localparam int unsigned OW   = IN_W / 2;
    localparam int unsigned OH   = IN_H / 2;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic [15:0]   iX = '0;
    logic [15:0]   iY = '0;
    logic [DW-1:0] oGray;
    logic          oDVAL;
    logic [9:0]    oX;
    logic [9:0]    oY;
    logic          oFrameDone;

    bayer_gray_downscaler #(
        .IN_W (IN_W),
        .IN_H (IN_H),
        .DW   (DW)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iDVAL      (iDVAL),
        .iX         (iX),
        .iY         (iY),
        .oGray      (oGray),
        .oDVAL      (oDVAL),
        .oX         (oX),
        .oY         (oY),
        .oFrameDone (oFrameDone)
    );

    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        int g;
        int x;
        int y;
        bit last;
        int cyc;
    } exp_t;

    logic [DW-1:0] img [IN_H][IN_W];
    exp_t          expq[$];
    bit            sof_seen = 1'b0;
    int            cyc = 0;
    int            strobes = 0;
    int            fdones = 0;
    int            mode = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Drive one cycle and feed the image model with every in-range valid pixel.
    task automatic drive(input bit v, input int x, input int y, input logic [DW-1:0] d);
        int s;
        exp_t e;
        @(posedge iCLK);
        #1;
        iDVAL = v;
        iX    = 16'(x);
        iY    = 16'(y);
        iDATA = d;
        if (v && x < IN_W && y < IN_H) begin
            if (x == 0 && y == 0) sof_seen = 1'b1;
            if (sof_seen) begin
                img[y][x] = d;
                if ((x % 2 == 1) && (y % 2 == 1)) begin
                    s = int'(img[y-1][x-1]) + int'(img[y-1][x]) + int'(img[y][x-1]) + int'(d);
                    e.g    = s / 4;
                    e.x    = x / 2;
                    e.y    = y / 2;
                    e.last = (x == IN_W - 1) && (y == IN_H - 1);
                    e.cyc  = cyc + 2;
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, int'($urandom_range(0, IN_W - 1)), int'($urandom_range(0, IN_H - 1)),
              DW'($urandom));
    endtask

    function automatic logic [DW-1:0] pix(input int m, input int x, input int y);
        logic [DW-1:0] r;
        r = DW'($urandom);
        if (m == 0) r = 12'h800;
        if (m == 2 && y < 2) begin
            if (x == 0) r = (y == 0) ? 12'h001 : 12'h003;
            if (x == 1) r = (y == 0) ? 12'h002 : 12'hFFF;
            if (x == 2 || x == 3) r = 12'hFFF;
            if (x == 4) r = 12'h001;
            if (x == 5) r = (y == 0) ? 12'h001 : 12'h000;
        end
        return r;
    endfunction

    // Raster rows y0..y1-1; optional random gaps / out-of-range cycles, and a
    // fixed 5-cycle hole before column 3 of gap_row.
    task automatic send_rows(input int m, input int y0, input int y1, input bit noisy, input int gap_row);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < int'(IN_W); x++) begin
                if (y == gap_row && x == 3) repeat (5) idle();
                if (noisy && $urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0: idle();
                        1: drive(1'b1, int'(IN_W) + int'($urandom_range(0, 40)), y, DW'($urandom));
                        default: drive(1'b1, x, int'(IN_H) + int'($urandom_range(0, 40)), DW'($urandom));
                    endcase
                end
                drive(1'b1, x, y, pix(m, x, y));
            end
        end
    endtask

    task automatic drain();
        repeat (4) idle();
    endtask

    task automatic frame_end(input string tag, input int exp_strobes, input int exp_fd);
        drain();
        check({tag, "_queue_left"}, expq.size(), 0);
        check({tag, "_strobes"}, strobes, exp_strobes);
        check({tag, "_framedone"}, fdones, exp_fd);
        strobes = 0;
        fdones  = 0;
    endtask

    task automatic reset_pulse();
        iRST     = 1'b0;
        sof_seen = 1'b0;
        expq.delete();
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b1;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST) begin
            if (oFrameDone) begin
                fdones++;
                check("framedone_with_dval", oDVAL, 1);
            end
            if (oDVAL) begin
                strobes++;
                if (expq.size() == 0) begin
                    check("unexpected_dval", oDVAL, 0);
                end else begin
                    e = expq.pop_front();
                    check("gray", oGray, e.g);
                    check("ox", oX, e.x);
                    check("oy", oY, e.y);
                    check("framedone", oFrameDone, e.last);
                    check("latency_cyc", cyc, e.cyc);
                    if (mode == 2 && oY == 0 && oX == 0) check("quad_sum_1005", oGray, 12'h401);
                    if (mode == 2 && oY == 0 && oX == 1) check("quad_all_fff", oGray, 12'hFFF);
                    if (mode == 2 && oY == 0 && oX == 2) check("quad_trunc", oGray, 12'h000);
                end
            end
        end
    end

    initial begin
        // Reset values, including asynchronous assertion before any clock edge.
        #2;
        check("rst_gray", oGray, 0);
        check("rst_dval", oDVAL, 0);
        check("rst_x", oX, 0);
        check("rst_y", oY, 0);
        check("rst_fd", oFrameDone, 0);
        reset_pulse();

        // Flat frame: every quad averages to the same value.
        mode = 0;
        send_rows(0, 0, IN_H, 1'b0, -1);
        frame_end("flat", OW * OH, 1);

        // Directed quads plus a 5-cycle hole inside an odd-row quad.
        mode = 2;
        send_rows(2, 0, IN_H, 1'b0, 3);
        frame_end("directed", OW * OH, 1);
        mode = 1;

        // Back-to-back random frames with gaps and out-of-range cycles.
        for (int f = 0; f < 3; f++) begin
            send_rows(1, 0, IN_H, 1'b1, -1);
            frame_end("random", OW * OH, 1);
        end

        // Reset in the middle of a row: outputs clear at once, then stay quiet.
        send_rows(1, 0, 7, 1'b1, -1);
        for (int x = 0; x < 6; x++) drive(1'b1, x, 7, DW'($urandom));
        #3;
        iRST = 1'b0;
        #1;
        check("midrst_gray", oGray, 0);
        check("midrst_dval", oDVAL, 0);
        check("midrst_x", oX, 0);
        check("midrst_y", oY, 0);
        check("midrst_fd", oFrameDone, 0);
        strobes = 0;
        fdones  = 0;
        reset_pulse();
        for (int x = 6; x < int'(IN_W); x++) drive(1'b1, x, 7, DW'($urandom));
        send_rows(1, 8, IN_H, 1'b1, -1);
        frame_end("after_rst_tail", 0, 0);
        send_rows(1, 0, IN_H, 1'b1, -1);
        frame_end("after_rst_frame", OW * OH, 1);

        // Stream picked up mid-frame after reset.
        reset_pulse();
        send_rows(1, 5, IN_H, 1'b1, -1);
        frame_end("midframe_start", 0, 0);
        send_rows(1, 0, IN_H, 1'b1, -1);
        frame_end("midframe_next", OW * OH, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bayer_gray_downscaler.md
Name: bayer_gray_downscaler

Overview:
- Upstream neighbour of the 3x3 window/Sobel shift-register stage.
- Takes the 12-bit Bayer raw stream from CCD capture at 1280x960, with pixel X/Y counts.
- Averages each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit gray pixel and emits a 640x480 stream with oDVAL, oX, oY.
- Those outputs feed the window stage's grayVal, iDVAL, iX and iY inputs directly.

Parameters:
- IN_W, 1280, input pixels per row (even).
- IN_H, 960, input rows per frame (even).
- DW, 12, pixel data width.

Ports:
- iCLK  input  1  pixel clock.
- iRST  input  1  asynchronous active-low reset.
- iDATA  input  DW  raw Bayer pixel.
- iDVAL  input  1  iDATA/iX/iY valid this cycle.
- iX  input  16  input column, 0..IN_W-1.
- iY  input  16  input row, 0..IN_H-1.
- oGray  output  DW  averaged gray pixel.
- oDVAL  output  1  one-cycle strobe, oGray/oX/oY valid.
- oX  output  10  output column = iX>>1 of the quad's odd column.
- oY  output  10  output row = iY>>1 of the quad's odd row.
- oFrameDone  output  1  one-cycle pulse with the last output pixel (639,479).

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is asynchronous, active-low.
- Reset values: oGray=0, oDVAL=0, oX=0, oY=0, oFrameDone=0, FSM=WAIT_SOF, held-pixel register=0.
- Line buffer contents are not reset (don't-care).
- FSM has two states:
  - WAIT_SOF: all input is ignored and oDVAL stays 0. Moves to ACTIVE on a cycle with iDVAL=1, iX=0, iY=0; that pixel is processed normally.
  - ACTIVE: normal operation. Returns to WAIT_SOF only on reset.
  - Purpose: a reset mid-frame never emits quads built from stale line-buffer data.
- Valid input: iDVAL=1 with iX<IN_W and iY<IN_H. Out-of-range cycles are ignored entirely: no buffer write, no output.
- Line buffer: IN_W x DW. Every valid input in ACTIVE writes iDATA at address iX. Reads return the previous row's value (read-before-write), so single-port RAM inference is allowed.
- Held pixel: every valid input registers iDATA as the current row's col-1 value.
- Quad trigger: a valid input with iX odd and iY odd. The quad is:
  - above-left = buf[iX-1]
  - above = buf[iX]
  - left = held pixel
  - current = iDATA
- Arithmetic: sum is DW+2 = 14 bits unsigned, no overflow. oGray = sum[13:2], truncating (floor).
- Latency: exactly 2 cycles from the triggering iDVAL cycle to oDVAL=1. The pipeline accepts a trigger every cycle; no stalls, no backpressure.
- oDVAL is high for exactly one cycle per trigger. oGray/oX/oY hold their last values while oDVAL=0.
- Output count: 640x480 = 307200 strobes per frame, in raster order.
- oFrameDone asserts in the same cycle as oDVAL for oX=639, oY=479.
- A gap in iDVAL between the two pixels of a quad is tolerated, because the held pixel updates only on valid input.
- Even rows and even columns never produce output.
- Back-to-back frames: the iY wrap 959->0 needs no special handling in ACTIVE.

Decomposition:
- Shared package gray_pkg holds:
  - localparams for the widths: DW=12, SUM_W=14, OUT_X_W=10, OUT_Y_W=10.
  - OUT_W=640, OUT_H=480.
  - FSM enum typedef {WAIT_SOF, ACTIVE}.
- Separate the buffer as sub-module gray_line_buffer: simple single-port RAM with registered read, IN_W deep, DW wide, read-before-write.

Test Plan:
1. Reset, then a frame where every pixel value is 0x800 -> 307200 oDVAL strobes, all with oGray=0x800; oFrameDone exactly once, at (639,479).
2. Quad at rows 0-1, cols 0-1 = 0x001, 0x002, 0x003, 0xFFF (sum 0x1005) -> oGray=0x401 at oX=0, oY=0, oDVAL 2 cycles after the (1,1) input.
3. All four quad pixels = 0xFFF -> oGray=0xFFF (no overflow). Quad 1,1,1,0 -> oGray=0 (truncation).
4. Stream begins mid-frame (first iY=37) after reset -> no oDVAL until iX=0, iY=0 is seen; the next frame's outputs are correct.
5. iDVAL deasserted for 5 cycles between iX=2 and iX=3 on an odd row -> correct average, emitted 2 cycles after the iX=3 input.
6. Assert iRST during row 500 -> outputs go to 0 immediately (asynchronously); after release, no output until the next start of frame.
